// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared state type, default timing constants and counter sizing
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int REPEAT_CYCLES_DEF   = 25000000;

  // Bits needed to hold a count of 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterized two-flop synchronizer with selectable reset value
module sync_2ff #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - debounced push-button to one-cycle load strobe with switch snapshot
// Optional auto-repeat while held: KEY_EVENT_CTRL_AUTOREPEAT_EN
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter int SW_W            = 10
) (
  input  logic            clk100_i,
  input  logic            rstn_i,
  input  logic            key_ni,
  input  logic [SW_W-1:0] sw_i,
  output logic            load_o,
  output logic [SW_W-1:0] data_o,
  output logic            busy_o,
  output logic [7:0]      press_cnt_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be within 2..2^20");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 2");
  end

  logic            key_sync;
  logic [SW_W-1:0] sw_sync;

  sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync_key (
    .clk_i  (clk100_i),
    .rst_ni (rstn_i),
    .d_i    (key_ni),
    .q_o    (key_sync)
  );

  sync_2ff #(.W(SW_W), .RST_VAL('0)) u_sync_sw (
    .clk_i  (clk100_i),
    .rst_ni (rstn_i),
    .d_i    (sw_i),
    .q_o    (sw_sync)
  );

  key_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            load_q, load_d;
  logic [SW_W-1:0] data_q, data_d;
  logic            busy_q, busy_d;
  logic [7:0]      press_cnt_q, press_cnt_d;
  logic            fire;

`ifdef KEY_EVENT_CTRL_AUTOREPEAT_EN
  localparam int REP_W = cnt_width(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_d      = 1'b0;
    data_d      = data_q;
    press_cnt_d = press_cnt_q;
    fire        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!key_sync) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (key_sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (key_sync) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!key_sync) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

`ifdef KEY_EVENT_CTRL_AUTOREPEAT_EN
    // A fresh press restarts the repeat interval; a release bounce only pauses it.
    rep_d = rep_q;
    if (state_q == PRESS_WAIT && state_d == PRESSED) begin
      rep_d = '0;
    end else if (state_q == PRESSED && state_d == PRESSED) begin
      if (rep_q == REP_MAX) begin
        rep_d = '0;
        fire  = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
`endif

    if (fire) begin
      load_d      = 1'b1;
      data_d      = sw_sync;
      press_cnt_d = press_cnt_q + 8'd1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_q      <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_q      <= load_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      press_cnt_q <= press_cnt_d;
    end
  end

`ifdef KEY_EVENT_CTRL_AUTOREPEAT_EN
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) rep_q <= '0;
    else         rep_q <= rep_d;
  end
`endif

  assign load_o      = load_q;
  assign data_o      = data_q;
  assign busy_o      = busy_q;
  assign press_cnt_o = press_cnt_q;

endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Front-end controller that sequences the board counter datapath from raw board inputs. It synchronizes and debounces the active-low push-button and samples the switch bank. For each accepted press it issues a single-cycle load strobe with a stable switch snapshot. It sits between the board pins and the counter/display datapath, which must see only clean, one-cycle events.

## Interface
- DEBOUNCE_CYCLES, 500000: cycles key must be stable before a press/release is accepted; legal range 2..2^20.
- REPEAT_CYCLES, 25000000: hold time between auto-repeat strobes (used only with autorepeat compiled in); legal range ≥2.
- SW_W, 10: switch bank width.
- clk100_i  input  1  system clock, rising edge.
- rstn_i  input  1  reset; one clock, reset is asynchronous and active-low.
- key_ni  input  1  raw push-button, active-low, asynchronous to clk100_i.
- sw_i  input  SW_W  raw switches, asynchronous.
- load_o  output  1  one-cycle strobe per accepted press (and per repeat).
- data_o  output  SW_W  switch snapshot captured with the latest load_o, held until the next one.
- busy_o  output  1  high whenever FSM is not IDLE.
- press_cnt_o  output  8  count of load_o strobes, wraps 255→0.

## Operation
- key_ni and sw_i each pass through a 2-flop synchronizer (reset values: key 1, sw 0).
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. The debounce counter is cleared on every state change.
- IDLE: key_sync==0 → PRESS_WAIT.
- PRESS_WAIT: key_sync==1 → IDLE (bounce rejected, no strobe). The counter increments while key_sync==0. At count==DEBOUNCE_CYCLES-1 with key_sync==0 → PRESSED; on that edge load_o=1, data_o←sw_sync, press_cnt_o+1.
- PRESSED: key_sync==1 → RELEASE_WAIT.
- RELEASE_WAIT: key_sync==0 → PRESSED (release bounce, no new strobe). At count==DEBOUNCE_CYCLES-1 with key_sync==1 → IDLE.
- load_o is registered and is never high on two consecutive cycles. The exception is autorepeat with REPEAT_CYCLES==… (forbidden by the range rule).
- press_cnt_o is modulo-256. At 255 a strobe produces 0.
- Reset asserted mid-operation: all state clears immediately (asynchronously), and no strobe is emitted.
- After reset release with the key already held: the FSM passes through PRESS_WAIT normally, so exactly one strobe is issued after the debounce period.

## Timing
- Reset values: load_o=0, data_o=0, busy_o=0, press_cnt_o=0, FSM=IDLE, counters=0.
- Press latency: key_ni is first sampled low at edge 1, so load_o is high after edge 3+DEBOUNCE_CYCLES, for exactly one cycle.
- busy_o is registered from state. It goes high after edge 3 of a press and low after the release debounce completes.
- data_o reflects sw_i as sampled 2 edges before the strobe edge. A switch change within those 2 cycles is not guaranteed to be captured.

## Configuration
- KEY_EVENT_CTRL_AUTOREPEAT_EN defined:
  - In PRESSED, a repeat counter runs. Each time it reaches REPEAT_CYCLES-1 it issues a load_o, a data_o capture and a press_cnt_o increment, then restarts from 0.
  - The repeat counter is cleared on entry to PRESSED.
  - RELEASE_WAIT freezes the repeat counter; a bounce back to PRESSED resumes it.
- Macro undefined: the repeat logic is absent, and exactly one strobe is issued per debounced press.

## Structure
- Shared package key_event_pkg:
  - FSM state enum: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - Default constants DEBOUNCE_CYCLES_DEF and REPEAT_CYCLES_DEF.
  - Counter-width helper based on $clog2.
- One sub-module, sync_2ff: a parameterized-width 2-flop synchronizer with an asynchronous active-low reset and a reset-value parameter. It is instantiated for the key and for the switches.

## Test plan
1. Clean press (DEBOUNCE_CYCLES=4): sw_i=10'h2A5, key_ni low for 20 cycles then high → one load_o at edge 7, data_o=10'h2A5, press_cnt_o=1, busy_o back to 0 after 4+3 cycles of released key.
2. Press bounce: key_ni low 2 cycles, high 1, low 10 → the short pulse is rejected and a single load_o occurs, press_cnt_o=1.
3. Release bounce: while PRESSED, key_ni high 2 cycles, low 1, high → no extra strobe, and the FSM reaches IDLE after the final debounce.
4. Wrap: 256 clean presses → press_cnt_o returns to 0, and each press yields exactly one 1-cycle load_o.
5. Reset mid-debounce: rstn_i low during PRESS_WAIT → outputs return to reset values at once and no load_o; a key still held after release → one strobe after edge 3+DEBOUNCE_CYCLES.
6. With KEY_EVENT_CTRL_AUTOREPEAT_EN, REPEAT_CYCLES=8: key held 30 cycles past the first strobe → strobes at first+8, +16, +24 (press_cnt_o=4), and data_o tracks sw_i changes at each strobe.
